axi_sram_slave: RTL and testbench

//  AXI3 responder (slave) backed by a single-port-per-channel word RAM; the target end of the
//  CPU-top AXI master bus. Independent read and write engines, one outstanding transaction each,

---
 rtl/axi_slv_pkg.sv | 49 ++++
 rtl/axi_slv_burst_addr.sv | 39 +++
 rtl/axi_sram_slave.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_pkg.sv
// Shared definitions for the AXI3 SRAM responder: burst and response codes,
// read/write engine state encodings and small address/legality helpers.
// Build option: define AXI_SLV_WRAP_EN to execute burst 2'b10 as a WRAP burst;
// without it, 2'b10 is executed as INCR with an OKAY response.
package axi_slv_pkg;

`ifdef AXI_SLV_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] W_IDLE = 2'b00;
  localparam logic [1:0] W_DATA = 2'b01;
  localparam logic [1:0] W_RESP = 2'b10;

  // True when addr lies inside [base, base + 4*words).
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input int unsigned words);
    return (addr >= base) && (((addr - base) >> 2) < words);
  endfunction

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  // Transaction-level error: oversize beat, reserved burst, or illegal wrap length.
  function automatic logic burst_err(input logic [2:0] size, input logic [3:0] len,
                                     input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) ||
           (WRAP_EN && (burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

  // Beats wider than the 32-bit bus are executed as 4-byte beats.
  function automatic logic [1:0] eff_size(input logic [2:0] size);
    return (size > 3'd2) ? 2'd2 : size[1:0];
  endfunction

endpackage

// File: rtl/axi_slv_burst_addr.sv
// Combinational next-beat address for one AXI burst.
// Ports: addr (current beat byte address), size (log2 bytes, already clamped to 0..2),
//        len (beats-1), burst (type) -> next_addr.
// Build option: AXI_SLV_WRAP_EN (via axi_slv_pkg::WRAP_EN) enables WRAP stepping.
module axi_slv_burst_addr
  import axi_slv_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [3:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] step;
  logic [31:0] aligned;
  logic [31:0] incr_addr;
  logic [31:0] span_mask;
  logic [31:0] wrap_addr;

  assign step      = 32'd1 << size;
  // An unaligned first beat aligns down before stepping.
  assign aligned   = addr & ~(step - 32'd1);
  assign incr_addr = aligned + step;
  // Wrap span is (len+1) beats; legal lengths make this a power of two.
  assign span_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
  assign wrap_addr = (aligned & ~span_mask) | (incr_addr & span_mask);

  always_comb begin
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP:  next_addr = (WRAP_EN && wrap_len_ok(len)) ? wrap_addr : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a word RAM. Independent read and write engines, one
// outstanding transaction each, INCR/FIXED bursts up to 16 beats.
// Build option: AXI_SLV_WRAP_EN enables WRAP bursts (burst 2'b10).
// Ports: aclk/areset (sync, active-high); AR/R read channels; AW/W/B write channels.
//        Lock/cache/prot and wid are accepted but ignored.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_DATA | streaming read beats, one per rvalid&rready
// W_IDLE | awready high, wready low (write data before address is stalled)
// W_DATA | wready high, each beat written under wstrb until wlast
// W_RESP | bvalid high until bready
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h1faf_0000,
  parameter logic [1:0]  ERR_RESP  = RESP_SLVERR
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  logic unused_sideband;
  assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // ---------------- read engine ----------------
  logic [0:0]  r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_len;
  logic [3:0]  r_cnt;
  logic [3:0]  r_cnt_nxt;
  logic [1:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_txn_err;
  logic [31:0] r_next_addr;
  logic [31:0] rd_addr;
  logic        rd_in_win;
  logic        rd_txn_err;
  logic [31:0] rd_beat_data;
  logic [1:0]  rd_beat_resp;

  axi_slv_burst_addr u_rd_addr (
    .addr      (r_addr),
    .size      (r_size),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (r_next_addr)
  );

  // The word fetched this cycle: first beat on the AR handshake, else the next beat.
  assign rd_addr      = (r_state == R_IDLE) ? araddr : r_next_addr;
  assign rd_txn_err   = (r_state == R_IDLE) ? burst_err(arsize, arlen, arburst) : r_txn_err;
  assign rd_in_win    = in_window(rd_addr, BASE_ADDR, MEM_WORDS);
  assign rd_beat_data = rd_in_win ? mem[rd_addr[2 +: IDX_W]] : 32'd0;
  assign rd_beat_resp = (rd_txn_err || !rd_in_win) ? ERR_RESP : RESP_OKAY;
  assign r_cnt_nxt    = r_cnt + 4'd1;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= R_IDLE;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rdata     <= 32'd0;
      rresp     <= RESP_OKAY;
      rid       <= 4'd0;
      r_addr    <= 32'd0;
      r_len     <= 4'd0;
      r_cnt     <= 4'd0;
      r_size    <= 2'd0;
      r_burst   <= BURST_FIXED;
      r_txn_err <= 1'b0;
    end else if (r_state == R_IDLE) begin
      if (arvalid && arready) begin
        r_state   <= R_DATA;
        arready   <= 1'b0;
        rid       <= arid;
        r_addr    <= araddr;
        r_len     <= arlen;
        r_cnt     <= 4'd0;
        r_size    <= eff_size(arsize);
        r_burst   <= arburst;
        r_txn_err <= rd_txn_err;
        rvalid    <= 1'b1;
        rlast     <= (arlen == 4'd0);
        rdata     <= rd_beat_data;
        rresp     <= rd_beat_resp;
      end else begin
        arready <= 1'b1;
      end
    end else if (rready) begin
      // rvalid is continuously high in R_DATA, so rready alone completes a beat.
      if (rlast) begin
        r_state <= R_IDLE;
        rvalid  <= 1'b0;
        rlast   <= 1'b0;
        arready <= 1'b1;
      end else begin
        r_addr <= r_next_addr;
        r_cnt  <= r_cnt_nxt;
        rlast  <= (r_cnt_nxt == r_len);
        rdata  <= rd_beat_data;
        rresp  <= rd_beat_resp;
      end
    end
  end

  // ---------------- write engine ----------------
  logic [1:0]  w_state;
  logic [31:0] w_addr;
  logic [3:0]  w_len;
  logic [3:0]  w_cnt;
  logic [1:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err;
  logic [31:0] w_next_addr;
  logic        wr_in_win;
  logic        w_beat_err;
  logic        mem_we;

  axi_slv_burst_addr u_wr_addr (
    .addr      (w_addr),
    .size      (w_size),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next_addr)
  );

  assign wr_in_win  = in_window(w_addr, BASE_ADDR, MEM_WORDS);
  // wlast must coincide with beat awlen; either an early wlast or a missing one is an error.
  // Once flagged the error is sticky, so w_cnt wrapping on an overlong burst is harmless.
  assign w_beat_err = !wr_in_win || (wlast != (w_cnt == w_len));
  assign mem_we     = wvalid && wready && wr_in_win && !areset;

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= 4'd0;
      w_addr  <= 32'd0;
      w_len   <= 4'd0;
      w_cnt   <= 4'd0;
      w_size  <= 2'd0;
      w_burst <= BURST_FIXED;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_state <= W_DATA;
            awready <= 1'b0;
            wready  <= 1'b1;
            bid     <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_cnt   <= 4'd0;
            w_size  <= eff_size(awsize);
            w_burst <= awburst;
            w_err   <= burst_err(awsize, awlen, awburst);
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            if (wlast) begin
              w_state <= W_RESP;
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err || w_beat_err) ? ERR_RESP : RESP_OKAY;
            end else begin
              w_addr <= w_next_addr;
              w_cnt  <= w_cnt + 4'd1;
              w_err  <= w_err || w_beat_err;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
          end
        end
        default: begin
          w_state <= W_IDLE;
          wready  <= 1'b0;
          bvalid  <= 1'b0;
          awready <= 1'b0;
        end
      endcase
    end
  end

  // RAM is not reset; a read of the same word in the same cycle sees the old value.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_addr[2 +: IDX_W]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

  localparam logic [31:0] BASE  = 32'h1faf_0000;
  localparam int          WORDS = 16384;
`ifdef AXI_SLV_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mdl [WORDS];
  logic [31:0] wd  [17];
  logic [3:0]  ws  [17];

  axi_sram_slave dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_in_win(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < 32'(WORDS));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic bit m_wrap(input logic [3:0] len, input logic [1:0] burst);
    return WRAP_ON && (burst == 2'b10) && (len inside {4'd1, 4'd3, 4'd7, 4'd15});
  endfunction

  function automatic bit m_txn_err(input logic [2:0] size, input logic [3:0] len,
                                   input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) ||
           (WRAP_ON && (burst == 2'b10) && !m_wrap(len, burst));
  endfunction

  // Byte address of beat n of a burst, from the AXI addressing rules.
  function automatic logic [31:0] m_addr(input logic [31:0] start, input logic [2:0] size,
                                         input logic [3:0] len, input logic [1:0] burst,
                                         input int n);
    logic [31:0] nb, al, span, low;
    nb = (size > 3'd2) ? 32'd4 : (32'd1 << size);
    al = start - (start % nb);
    if (n == 0 || burst == 2'b00) return start;
    if (m_wrap(len, burst)) begin
      span = ({28'd0, len} + 32'd1) * nb;
      low  = al - (al % span);
      return low + ((al - low + 32'(n) * nb) % span);
    end
    return al + 32'(n) * nb;
  endfunction

  // ---------------- transaction tasks ----------------
  task automatic do_write(input string tag, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int nbeats, input bit gaps);
    logic [3:0]  id;
    logic [31:0] ba;
    bit          err;
    int          cyc;
    id  = 4'($urandom);
    err = m_txn_err(size, len, burst) || (nbeats != int'(len) + 1);
    @(negedge aclk);
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    cyc = 0;
    while (!awready && cyc < 50) begin @(negedge aclk); cyc++; end
    chk({tag, ":awready"}, 32'(awready), 32'd1);
    for (int i = 0; i < nbeats; i++) begin
      @(negedge aclk);
      awvalid = 1'b0;
      if (gaps) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 2) == 0) begin wvalid = 1'b0; @(negedge aclk); end
        end
      end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
      cyc = 0;
      while (!wready && cyc < 50) begin @(negedge aclk); cyc++; end
      chk({tag, ":wready"}, 32'(wready), 32'd1);
      ba = m_addr(a, size, len, burst, i);
      if (m_in_win(ba)) begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mdl[m_idx(ba)][8*b +: 8] = wd[i][8*b +: 8];
      end else begin
        err = 1'b1;
      end
    end
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    cyc = 0;
    while (!bvalid && cyc < 50) begin @(negedge aclk); cyc++; end
    chk({tag, ":bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, ":bresp"}, 32'(bresp), err ? 32'd2 : 32'd0);
    chk({tag, ":bid"}, 32'(bid), 32'(id));
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk({tag, ":b_done"}, {30'd0, bvalid, awready}, 32'd1);
  endtask

  // rr_mode: 0 rready always high, 1 toggles every cycle, 2 random.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int rr_mode);
    logic [3:0]  id;
    logic [31:0] ba, ew;
    bit          bad;
    int          cyc, beat;
    id  = 4'($urandom);
    bad = m_txn_err(size, len, burst);
    @(negedge aclk);
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 50) begin @(negedge aclk); cyc++; end
    chk({tag, ":arready"}, 32'(arready), 32'd1);
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 200) begin
      @(negedge aclk);
      cyc++;
      arvalid = 1'b0;
      if (cyc == 1) chk({tag, ":r_latency"}, 32'(rvalid), 32'd1);
      case (rr_mode)
        0:       rready = 1'b1;
        1:       rready = cyc[0];
        default: rready = ($urandom_range(0, 2) != 0);
      endcase
      if (rvalid) begin
        ba = m_addr(a, size, len, burst, beat);
        ew = m_in_win(ba) ? mdl[m_idx(ba)] : 32'd0;
        chk($sformatf("%s:rdata[%0d]", tag, beat), rdata, ew);
        chk($sformatf("%s:rresp[%0d]", tag, beat), 32'(rresp),
            (bad || !m_in_win(ba)) ? 32'd2 : 32'd0);
        chk($sformatf("%s:rlast[%0d]", tag, beat), 32'(rlast), 32'(beat == int'(len)));
        chk($sformatf("%s:rid[%0d]", tag, beat), 32'(rid), 32'(id));
        if (rready) beat++;
      end
    end
    chk({tag, ":beats"}, 32'(beat), 32'(len) + 32'd1);
    @(negedge aclk);
    rready = 1'b0;
    chk({tag, ":r_done"}, {29'd0, rvalid, rlast, arready}, 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] a;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nb, sel, cyc;

    areset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0;
    arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0;
    awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    for (int k = 0; k < WORDS; k++) mdl[k] = 32'd0;

    repeat (3) @(negedge aclk);
    chk("rst_ctl", {26'd0, arready, awready, wready, rvalid, rlast, bvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ids", {20'd0, rid, bid, rresp, bresp}, 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_ready", {29'd0, arready, awready, wready}, 32'b110);

    // single write then two-beat read back
    wd[0] = 32'habcdeef0; ws[0] = 4'hf;
    do_write("t1", 32'h1faf_f004, 4'd0, 3'd2, 2'b01, 1, 1'b0);
    do_read("t2", 32'h1faf_f004, 4'd1, 3'd2, 2'b01, 0);

    // INCR len 3 with a half-word strobe on beat 2
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    ws[0] = 4'hf;  ws[1] = 4'h3;  ws[2] = 4'hf;  ws[3] = 4'hf;
    do_write("t3", BASE, 4'd3, 3'd2, 2'b01, 4, 1'b0);
    do_read("t3r", BASE, 4'd3, 3'd2, 2'b01, 0);

    // 16-beat read with rready toggling
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hf; end
    do_write("t4w", BASE + 32'h100, 4'd15, 3'd2, 2'b01, 16, 1'b1);
    do_read("t4", BASE + 32'h100, 4'd15, 3'd2, 2'b01, 1);

    // out-of-window read and early wlast
    do_read("t5_oow", 32'h0000_1000, 4'd0, 3'd2, 2'b01, 0);
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hf; end
    do_write("t5_short", BASE + 32'h200, 4'd3, 3'd2, 2'b01, 2, 1'b0);

    // reset in the middle of a read burst
    @(negedge aclk);
    arid = 4'h5; araddr = BASE + 32'h100; arlen = 4'd15; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 50) begin @(negedge aclk); cyc++; end
    chk("t5_rst_ar", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b1; rready = 1'b0;
    @(negedge aclk);
    chk("t5_rst_abort", {29'd0, rvalid, rlast, arready}, 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("t5_rst_ready", {29'd0, rvalid, arready, awready}, 32'b011);
    do_read("t5_retain", BASE + 32'h100, 4'd3, 3'd2, 2'b01, 0);

    // WRAP len 3 from offset 8
    for (int i = 0; i < 6; i++) begin wd[i] = 32'hc0de_0000 + 32'(i); ws[i] = 4'hf; end
    do_write("t6w", BASE, 4'd5, 3'd2, 2'b01, 6, 1'b0);
    do_read("t6", BASE + 32'h8, 4'd3, 3'd2, 2'b10, 0);

    // randomized write/read-back pairs
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 15);
      a = BASE + 32'($urandom_range(0, 63)) * 32'd4;
      if (sel == 0)      a = BASE + 32'(4 * WORDS) - 32'($urandom_range(1, 4)) * 32'd4;
      else if (sel == 1) a = BASE - 32'd16;
      else if (sel == 2) a = a + 32'($urandom_range(1, 3));
      len   = 4'($urandom_range(0, 15));
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      burst = 2'($urandom_range(0, 3));
      nb = int'(len) + 1;
      if (sel == 3 && len > 4'd0)  nb = int'(len);
      if (sel == 4 && len < 4'd15) nb = int'(len) + 2;
      for (int i = 0; i < nb; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      do_write($sformatf("rnd%0d_w", t), a, len, size, burst, nb, 1'b1);
      do_read($sformatf("rnd%0d_r", t), a, len, size, burst, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
